// File: rtl/mc_ctrl_if.sv
// rtl/mc_ctrl_if.sv - IR fields, datapath status and control outputs between mc_ctrl and the MIPS datapath
interface mc_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       op;
  logic [5:0]       func;
  logic             zero;
  logic             mem_ready;
  logic [2:0]       state;
  logic             pc_we;
  logic             ir_we;
  logic             reg_we;
  logic             mem_we;
  logic [1:0]       reg_dst;
  logic             alu_src;
  logic [1:0]       ext_op;
  logic [3:0]       alu_op;
  logic [2:0]       npc_op;
  logic [1:0]       mem_to_reg;
  logic [CNT_W-1:0] instr_cnt;
  logic             illegal;
  logic             mem_err;

  modport master (
    input  op, func, zero, mem_ready,
    output state, pc_we, ir_we, reg_we, mem_we, reg_dst, alu_src, ext_op,
           alu_op, npc_op, mem_to_reg, instr_cnt, illegal, mem_err
  );

  modport slave (
    output op, func, zero, mem_ready,
    input  state, pc_we, ir_we, reg_we, mem_we, reg_dst, alu_src, ext_op,
           alu_op, npc_op, mem_to_reg, instr_cnt, illegal, mem_err
  );
endinterface

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multi-cycle MIPS control FSM with DM ready watchdog and retired-instruction counter
module mc_ctrl #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic      clk,
  input  logic      reset,
  mc_ctrl_if.master bus
);
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q;
  logic [CNT_W-1:0]  cnt_q;

  logic       pc_we, ir_we, reg_we, mem_we, alu_src, illegal, mem_err;
  logic [1:0] reg_dst, ext_op, mem_to_reg;
  logic [3:0] alu_op;
  logic [2:0] npc_op;

  logic is_r, i_addu, i_subu, i_jr, i_ori, i_lui, i_lw, i_sw, i_beq, i_j, i_jal, legal;

  assign is_r   = (bus.op == 6'h00);
  assign i_addu = is_r && (bus.func == 6'h21);
  assign i_subu = is_r && (bus.func == 6'h23);
  assign i_jr   = is_r && (bus.func == 6'h08);
  assign i_ori  = (bus.op == 6'h0D);
  assign i_lui  = (bus.op == 6'h0F);
  assign i_lw   = (bus.op == 6'h23);
  assign i_sw   = (bus.op == 6'h2B);
  assign i_beq  = (bus.op == 6'h04);
  assign i_j    = (bus.op == 6'h02);
  assign i_jal  = (bus.op == 6'h03);
  assign legal  = i_addu | i_subu | i_jr | i_ori | i_lui | i_lw | i_sw | i_beq | i_j | i_jal;

  always_comb begin
    state_d    = state_q;
    pc_we      = 1'b0;
    ir_we      = 1'b0;
    reg_we     = 1'b0;
    mem_we     = 1'b0;
    reg_dst    = 2'b00;
    alu_src    = 1'b0;
    ext_op     = 2'b00;
    alu_op     = 4'd0;
    npc_op     = 3'b000;
    mem_to_reg = 2'b00;
    illegal    = 1'b0;
    mem_err    = 1'b0;

    // ALU/EXT controls stay valid from EXEC through WB so MEM address and WB data are stable
    if (state_q == EXEC || state_q == MEM || state_q == WB) begin
      alu_op  = (i_subu | i_beq) ? 4'd1 : (i_ori ? 4'd2 : 4'd0);
      alu_src = i_ori | i_lui | i_lw | i_sw;
      ext_op  = i_lui ? 2'b10 : ((i_lw | i_sw) ? 2'b01 : 2'b00);
    end

    case (state_q)
      FETCH: begin
        ir_we   = 1'b1;
        state_d = DECODE;
      end
      DECODE: begin
        if (!legal) begin
          pc_we   = 1'b1;
          illegal = 1'b1;
          state_d = FETCH;
        end else if (i_j || i_jal) begin
          pc_we   = 1'b1;
          npc_op  = 3'b010;
          state_d = FETCH;
          if (i_jal) begin
            reg_we     = 1'b1;
            reg_dst    = 2'b10;
            mem_to_reg = 2'b10;
          end
        end else if (i_jr) begin
          pc_we   = 1'b1;
          npc_op  = 3'b011;
          state_d = FETCH;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (i_beq) begin
          pc_we   = 1'b1;
          npc_op  = bus.zero ? 3'b001 : 3'b000;
          state_d = FETCH;
        end else if (i_lw || i_sw) begin
          state_d = MEM;
        end else begin
          state_d = WB;
        end
      end
      MEM: begin
        mem_we = i_sw;
        // a ready arriving in the last allowed cycle still completes the access
        if (bus.mem_ready) begin
          if (i_sw) begin
            pc_we   = 1'b1;
            state_d = FETCH;
          end else begin
            state_d = WB;
          end
        end else if (wait_q == WAIT_LAST) begin
          mem_err = 1'b1;
          mem_we  = 1'b0;
          pc_we   = 1'b1;
          state_d = FETCH;
        end
      end
      WB: begin
        reg_we     = 1'b1;
        pc_we      = 1'b1;
        reg_dst    = (i_addu | i_subu) ? 2'b01 : 2'b00;
        mem_to_reg = i_lw ? 2'b01 : 2'b00;
        state_d    = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH;
      wait_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= (state_q == MEM && state_d == MEM) ? wait_q + WAIT_W'(1) : '0;
      if (pc_we) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // outputs are gated by reset so an abort drops every write enable without waiting for a clock
  assign bus.state      = state_q;
  assign bus.pc_we      = reset & pc_we;
  assign bus.ir_we      = reset & ir_we;
  assign bus.reg_we     = reset & reg_we;
  assign bus.mem_we     = reset & mem_we;
  assign bus.alu_src    = reset & alu_src;
  assign bus.illegal    = reset & illegal;
  assign bus.mem_err    = reset & mem_err;
  assign bus.reg_dst    = reset ? reg_dst : 2'b00;
  assign bus.ext_op     = reset ? ext_op : 2'b00;
  assign bus.alu_op     = reset ? alu_op : 4'd0;
  assign bus.npc_op     = reset ? npc_op : 3'b000;
  assign bus.mem_to_reg = reset ? mem_to_reg : 2'b00;
  assign bus.instr_cnt  = cnt_q;
endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - self-checking bench for mc_ctrl: directed vectors, random instructions vs model, reset corners
module tb_mc_ctrl;
  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 16;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int nerr = 0;
  int nchk = 0;
  int exp_cnt = 0;
  logic [5:0] cur_op = 6'h00;
  logic [5:0] cur_func = 6'h00;

  mc_ctrl_if #(.CNT_W(CNT_W)) bus();

  mc_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  // per-instruction expectations: latency, retire npc_op, write-enable cycle counts, held ALU controls
  typedef struct {
    logic [5:0] op;
    logic [5:0] func;
    logic       zero;
    int         n;
    int         lat;
    int         npc;
    int         rwe;
    int         rwe_st;
    int         rdst;
    int         m2r;
    int         mwe;
    int         ill;
    int         merr;
    int         aop;
    int         asrc;
    int         eop;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s (op=%02h func=%02h): got %0d expected %0d", name, cur_op, cur_func, act, exp);
    end
  endtask

  function automatic vec_t model(input logic [5:0] op, input logic [5:0] func, input logic zero, input int n);
    vec_t v;
    bit tmo;
    v = '{default: 0};
    v.op = op; v.func = func; v.zero = zero; v.n = n; v.rwe_st = 4;
    tmo = (n > TIMEOUT);
    if (op == 6'h00) begin
      case (func)
        6'h21:   begin v.lat = 4; v.rwe = 1; v.rdst = 1; end
        6'h23:   begin v.lat = 4; v.rwe = 1; v.rdst = 1; v.aop = 1; end
        6'h08:   begin v.lat = 2; v.npc = 3; end
        default: begin v.lat = 2; v.ill = 1; end
      endcase
    end else begin
      case (op)
        6'h0D: begin v.lat = 4; v.rwe = 1; v.aop = 2; v.asrc = 1; end
        6'h0F: begin v.lat = 4; v.rwe = 1; v.asrc = 1; v.eop = 2; end
        6'h23: begin
          v.asrc = 1; v.eop = 1;
          if (tmo) begin v.lat = 3 + TIMEOUT; v.merr = 1; end
          else begin v.lat = 4 + n; v.rwe = 1; v.m2r = 1; end
        end
        6'h2B: begin
          v.asrc = 1; v.eop = 1;
          v.lat  = 3 + (tmo ? TIMEOUT : n);
          v.mwe  = tmo ? TIMEOUT - 1 : n;
          v.merr = tmo ? 1 : 0;
        end
        6'h04:   begin v.lat = 3; v.aop = 1; v.npc = zero ? 1 : 0; end
        6'h02:   begin v.lat = 2; v.npc = 2; end
        6'h03:   begin v.lat = 2; v.npc = 2; v.rwe = 1; v.rdst = 2; v.m2r = 2; v.rwe_st = 1; end
        default: begin v.lat = 2; v.ill = 1; end
      endcase
    end
    return v;
  endfunction

  // starts just after a negedge with the DUT in FETCH, ends just after the negedge of the next FETCH
  task automatic run_instr(input vec_t v);
    int c, memk, pcw, npc, rwe, rwe_at, rdst, m2r, mwe, ill, merr, irw, alu_bad;
    c = 0; memk = 0; pcw = 0; npc = -1; rwe = 0; rwe_at = -1; rdst = -1; m2r = -1;
    mwe = 0; ill = 0; merr = 0; irw = 0; alu_bad = 0;
    cur_op = v.op; cur_func = v.func;
    bus.op = v.op; bus.func = v.func; bus.zero = v.zero; bus.mem_ready = 1'b0;
    do begin
      if (bus.state == 3'd3) memk++;
      bus.mem_ready = (bus.state == 3'd3) && (memk == v.n);
      #1;
      if (bus.ir_we) irw++;
      if (bus.pc_we) begin pcw++; npc = int'(bus.npc_op); end
      if (bus.reg_we) begin
        rwe++; rwe_at = int'(bus.state); rdst = int'(bus.reg_dst); m2r = int'(bus.mem_to_reg);
      end
      if (bus.mem_we) mwe++;
      if (bus.illegal) ill++;
      if (bus.mem_err) merr++;
      if (bus.state >= 3'd2 && bus.state <= 3'd4 &&
          (int'(bus.alu_op) != v.aop || int'(bus.alu_src) != v.asrc || int'(bus.ext_op) != v.eop))
        alu_bad++;
      c++;
      @(negedge clk);
    end while (bus.state != 3'd0 && c < 40);
    bus.mem_ready = 1'b0;
    exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
    chk("latency", c, v.lat);
    chk("pc_we_cycles", pcw, 1);
    chk("npc_op_at_retire", npc, v.npc);
    chk("ir_we_cycles", irw, 1);
    chk("reg_we_cycles", rwe, v.rwe);
    if (v.rwe != 0) begin
      chk("reg_we_state", rwe_at, v.rwe_st);
      chk("reg_dst", rdst, v.rdst);
      chk("mem_to_reg", m2r, v.m2r);
    end
    chk("mem_we_cycles", mwe, v.mwe);
    chk("illegal_pulses", ill, v.ill);
    chk("mem_err_pulses", merr, v.merr);
    chk("alu_ctrl_bad_cycles", alu_bad, 0);
    chk("instr_cnt", int'(bus.instr_cnt), exp_cnt);
  endtask

  initial begin
    vec_t tbl[17];
    vec_t rv;
    logic [5:0] rop, rfunc;

    bus.op = 6'h00; bus.func = 6'h00; bus.zero = 1'b0; bus.mem_ready = 1'b0;

    //          op     func   z     n    lat npc rwe st rdst m2r mwe ill merr aop asrc eop
    tbl[0]  = '{6'h0D, 6'h00, 1'b0, 1,   4,  0,  1,  4, 0,  0,  0,  0,  0,   2,  1,   0};
    tbl[1]  = '{6'h23, 6'h00, 1'b0, 4,   8,  0,  1,  4, 0,  1,  0,  0,  0,   0,  1,   1};
    tbl[2]  = '{6'h2B, 6'h00, 1'b0, 99,  19, 0,  0,  4, 0,  0,  15, 0,  1,   0,  1,   1};
    tbl[3]  = '{6'h2B, 6'h00, 1'b0, 16,  19, 0,  0,  4, 0,  0,  16, 0,  0,   0,  1,   1};
    tbl[4]  = '{6'h2B, 6'h00, 1'b0, 1,   4,  0,  0,  4, 0,  0,  1,  0,  0,   0,  1,   1};
    tbl[5]  = '{6'h23, 6'h00, 1'b0, 17,  19, 0,  0,  4, 0,  0,  0,  0,  1,   0,  1,   1};
    tbl[6]  = '{6'h23, 6'h00, 1'b0, 16,  20, 0,  1,  4, 0,  1,  0,  0,  0,   0,  1,   1};
    tbl[7]  = '{6'h04, 6'h00, 1'b1, 1,   3,  1,  0,  4, 0,  0,  0,  0,  0,   1,  0,   0};
    tbl[8]  = '{6'h04, 6'h00, 1'b0, 1,   3,  0,  0,  4, 0,  0,  0,  0,  0,   1,  0,   0};
    tbl[9]  = '{6'h03, 6'h00, 1'b0, 1,   2,  2,  1,  1, 2,  2,  0,  0,  0,   0,  0,   0};
    tbl[10] = '{6'h02, 6'h00, 1'b0, 1,   2,  2,  0,  4, 0,  0,  0,  0,  0,   0,  0,   0};
    tbl[11] = '{6'h00, 6'h08, 1'b0, 1,   2,  3,  0,  4, 0,  0,  0,  0,  0,   0,  0,   0};
    tbl[12] = '{6'h3F, 6'h00, 1'b0, 1,   2,  0,  0,  4, 0,  0,  0,  1,  0,   0,  0,   0};
    tbl[13] = '{6'h00, 6'h21, 1'b0, 1,   4,  0,  1,  4, 1,  0,  0,  0,  0,   0,  0,   0};
    tbl[14] = '{6'h00, 6'h23, 1'b0, 1,   4,  0,  1,  4, 1,  0,  0,  0,  0,   1,  0,   0};
    tbl[15] = '{6'h0F, 6'h00, 1'b0, 1,   4,  0,  1,  4, 0,  0,  0,  0,  0,   0,  1,   2};
    tbl[16] = '{6'h00, 6'h2A, 1'b0, 1,   2,  0,  0,  4, 0,  0,  0,  1,  0,   0,  0,   0};

    repeat (3) @(negedge clk);
    #1;
    chk("rst_state", int'(bus.state), 0);
    chk("rst_ir_we", int'(bus.ir_we), 0);
    chk("rst_pc_we", int'(bus.pc_we), 0);
    chk("rst_instr_cnt", int'(bus.instr_cnt), 0);
    chk("rst_illegal", int'(bus.illegal), 0);
    chk("rst_mem_err", int'(bus.mem_err), 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("release_state", int'(bus.state), 0);
    chk("release_ir_we", int'(bus.ir_we), 1);

    for (int i = 0; i < 17; i++) run_instr(tbl[i]);

    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 11))
        0:  begin rop = 6'h00; rfunc = 6'h21; end
        1:  begin rop = 6'h00; rfunc = 6'h23; end
        2:  begin rop = 6'h0D; rfunc = 6'($urandom); end
        3:  begin rop = 6'h0F; rfunc = 6'($urandom); end
        4:  begin rop = 6'h23; rfunc = 6'($urandom); end
        5:  begin rop = 6'h2B; rfunc = 6'($urandom); end
        6:  begin rop = 6'h04; rfunc = 6'($urandom); end
        7:  begin rop = 6'h02; rfunc = 6'($urandom); end
        8:  begin rop = 6'h03; rfunc = 6'($urandom); end
        9:  begin rop = 6'h00; rfunc = 6'h08; end
        10: begin rop = 6'($urandom); rfunc = 6'($urandom); end
        default: begin rop = 6'h00; rfunc = 6'($urandom); end
      endcase
      rv = model(rop, rfunc, 1'($urandom_range(0, 1)), int'($urandom_range(1, 20)));
      run_instr(rv);
    end

    // reset asserted mid-cycle while a store sits in MEM waiting for ready
    cur_op = 6'h2B; cur_func = 6'h00;
    bus.op = 6'h2B; bus.func = 6'h00; bus.zero = 1'b0; bus.mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("sw_in_mem_state", int'(bus.state), 3);
    chk("sw_in_mem_we", int'(bus.mem_we), 1);
    #1 reset = 1'b0;
    #1;
    chk("midrst_mem_we", int'(bus.mem_we), 0);
    chk("midrst_pc_we", int'(bus.pc_we), 0);
    chk("midrst_reg_we", int'(bus.reg_we), 0);
    chk("midrst_state", int'(bus.state), 0);
    chk("midrst_instr_cnt", int'(bus.instr_cnt), 0);
    @(negedge clk);
    reset = 1'b1;
    exp_cnt = 0;
    #1;
    chk("rerelease_ir_we", int'(bus.ir_we), 1);

    for (int i = 0; i < 16; i++) run_instr(model(6'h02, 6'h00, 1'b0, 1));
    chk("wrap_instr_cnt", int'(bus.instr_cnt), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", nerr + 1, nchk + 1);
    $fatal(1);
  end
endmodule
